// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default address width,
// the NOP encoding and the layout of one instruction-buffer entry.
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]           inst;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small circular FIFO with synchronous reset and flush.
// Storage is not reset; only pointers and occupancy are.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, one-cycle-latency memory
// requests, redirect/stall handling and a decoupling instruction buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int UW = CW + 1;
  localparam int EW = 32 + XLEN;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;

  logic [CW-1:0]   w_count;
  logic [UW-1:0]   w_used;
  logic [EW-1:0]   w_head;
  logic [EW-1:0]   w_push_data;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_unused_rpc_lsb;

  assign w_unused_rpc_lsb = redirect_pc[1:0];

  // Slots already claimed: buffered words plus the one in flight, minus the
  // one leaving this cycle. Keeps a slot reserved for every in-flight word.
  assign w_used   = UW'(w_count) + UW'(r_inflight) - UW'(w_pop);
  assign imem_req = ~rst & ~redirect & ~stall & (w_used < UW'(BUF_DEPTH));
  assign imem_addr = r_pc;

  assign inst_valid  = (w_count != '0) & ~rst;
  assign w_pop       = inst_valid & inst_ready & ~redirect;
  assign w_push      = r_inflight & ~rst & ~redirect;
  assign w_push_data = {imem_rdata, r_inflight_pc};

  assign inst    = inst_valid ? w_head[EW-1 -: 32] : '0;
  assign inst_pc = inst_valid ? w_head[XLEN-1:0]   : '0;

  // Stage p0 -> p1: request issue; PC advances, address captured for the response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) r_pc <= r_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) r_inflight_pc <= r_pc;
  end

  // Stage p1 -> p2: response pushed into the buffer, head visible next cycle
  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_flush(redirect),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(w_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: stream-level reference model plus directed scenarios
// and randomized redirect/stall/backpressure/reset traffic.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_ready = 1'b1;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;

  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        stall2 = 1'b0;
  logic        inst_ready2 = 1'b1;
  logic        imem_req2, inst_valid2;
  logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;

  logic [31:0] d_addr, d_addr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP;
  endfunction

  always @(posedge clk) begin
    d_addr  <= imem_addr;
    d_addr2 <= imem_addr2;
  end
  assign imem_rdata  = mem_word(d_addr);
  assign imem_rdata2 = mem_word(d_addr2);

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .stall(stall2), .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .inst(inst2), .inst_pc(inst_pc2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the requests issued since the last flush, in order, with
  // the cycle each was issued. A word may be presented 2 cycles after issue.
  fetch_entry_t q[$];
  int           qcyc[$];
  logic [31:0]  m_pc = '0;
  int           now = 0;
  logic         ev, er, epop;

  always @(negedge clk) begin
    ev   = !rst && (q.size() > 0) && (qcyc[0] <= now - 2);
    epop = ev && inst_ready && !redirect;
    er   = !rst && !redirect && !stall && ((q.size() - (epop ? 1 : 0)) < DEPTH);
    chk("m_inst_valid", 64'(inst_valid), 64'(ev));
    chk("m_imem_req", 64'(imem_req), 64'(er));
    if (er) chk("m_imem_addr", 64'(imem_addr), 64'(m_pc));
    if (ev) begin
      chk("m_inst_pc", 64'(inst_pc), 64'(q[0].pc));
      chk("m_inst", 64'(inst), 64'(q[0].inst));
    end
    if (rst) begin
      chk("m_rst_inst", 64'(inst), 64'd0);
      chk("m_rst_inst_pc", 64'(inst_pc), 64'd0);
    end
    if (rst) begin
      q.delete(); qcyc.delete();
      m_pc = 32'h0000_0000;
    end else if (redirect) begin
      q.delete(); qcyc.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (epop) begin
        void'(q.pop_front());
        void'(qcyc.pop_front());
      end
      if (er) begin
        q.push_back('{inst: mem_word(m_pc), pc: m_pc});
        qcyc.push_back(now);
        m_pc = m_pc + 32'd4;
      end
    end
    now++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_seq [3];
  logic [31:0] exp_wrap [3];
  logic [31:0] held;
  int          nreq;

  initial begin
    exp_seq[0] = 32'h0;  exp_seq[1] = 32'h4;  exp_seq[2] = 32'h8;
    exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC; exp_wrap[2] = 32'h0;

    repeat (3) next_cycle();

    // Free run from reset, both instances (sequential and wrapping RESET_PC)
    rst = 1'b0;
    @(negedge clk);
    chk("a_req_c0", 64'(imem_req), 64'd1);
    chk("a_addr_c0", 64'(imem_addr), 64'h0);
    chk("a_valid_c0", 64'(inst_valid), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_valid_seq", 64'(inst_valid), 64'd1);
      chk("a_pc_seq", 64'(inst_pc), 64'(exp_seq[i]));
      chk("w_valid_seq", 64'(inst_valid2), 64'd1);
      chk("w_pc_seq", 64'(inst_pc2), 64'(exp_wrap[i]));
    end

    // Redirect to an unaligned target while a word is in flight
    next_cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("r_req_in_redirect", 64'(imem_req), 64'd0);
    next_cycle();
    redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    chk("r_req_after", 64'(imem_req), 64'd1);
    chk("r_addr_after", 64'(imem_addr), 64'h100);
    chk("r_valid_after", 64'(inst_valid), 64'd0);
    @(negedge clk);
    chk("r_valid_c2", 64'(inst_valid), 64'd0);
    @(negedge clk);
    chk("r_valid_c3", 64'(inst_valid), 64'd1);
    chk("r_pc_c3", 64'(inst_pc), 64'h100);

    // Stall for three cycles with a word in flight
    next_cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s_req_stalled", 64'(imem_req), 64'd0);
      chk("s_addr_held", 64'(imem_addr), 64'h10C);
      if (i == 1) chk("s_inflight_delivered", 64'(inst_pc), 64'h108);
      if (i < 2) next_cycle();
    end
    next_cycle();
    stall = 1'b0;
    @(negedge clk);
    chk("s_resume_req", 64'(imem_req), 64'd1);
    chk("s_resume_addr", 64'(imem_addr), 64'h10C);

    // Backpressure from reset: buffer fills, requests stop, order preserved
    next_cycle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0; inst_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) nreq++;
      if (i < 9) next_cycle();
    end
    chk("b_req_count", 64'(nreq), 64'd2);
    chk("b_req_low", 64'(imem_req), 64'd0);
    chk("b_pc_held", 64'(inst_pc), 64'h0);
    next_cycle();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_valid_release", 64'(inst_valid), 64'd1);
      chk("b_pc_release", 64'(inst_pc), 64'(exp_seq[i]));
    end

    // Reset mid-operation: full buffer, then a word in flight
    next_cycle();
    inst_ready = 1'b0;
    repeat (3) next_cycle();
    inst_ready = 1'b1;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("x_valid_in_rst", 64'(inst_valid), 64'd0);
    chk("x_req_in_rst", 64'(imem_req), 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("x_valid_after", 64'(inst_valid), 64'd0);
    chk("x_req_after", 64'(imem_req), 64'd1);
    chk("x_addr_after", 64'(imem_addr), 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("x_pc_restart", 64'(inst_pc), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst         = ($urandom % 200) == 0;
      redirect    = ($urandom % 30) == 0;
      redirect_pc = $urandom;
      stall       = ($urandom % 5) == 0;
      inst_ready  = ($urandom % 10) < 7;
    end
    next_cycle();
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; inst_ready = 1'b1;
    repeat (5) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
